// File: rtl/decode_stage.sv
// RV32I decode stage: splits the fetched instruction into register indices,
// immediate, one-hot ALU op / opcode class and exception flags, one cycle late.
module decode_stage (
  input  logic               clk,
  input  logic               rst,
  input  logic [31:0]        fetch_instr,
  input  logic [31:0]        fetch_pc,
  output logic [31:0]        decode_pc,
  output logic [4:0]         decode_rs1,
  output logic [4:0]         decode_r_rs1,
  output logic [4:0]         decode_rs2,
  output logic [4:0]         decode_r_rs2,
  output logic [4:0]         decode_r_rd,
  output logic signed [31:0] decode_imm,
  output logic [2:0]         decode_funct3,
  output logic [13:0]        decode_alu_type,
  output logic [10:0]        decode_opcode_type,
  output logic [3:0]         decode_exception,
  input  logic               clk_en,
  output logic               next_clk_en,
  input  logic               stall,
  output logic               next_stall,
  input  logic               flush,
  output logic               next_flush
);

  localparam logic [6:0] OPC_RTYPE  = 7'b0110011;
  localparam logic [6:0] OPC_ITYPE  = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;

  localparam logic [10:0] CLS_RTYPE  = 11'h001;
  localparam logic [10:0] CLS_ITYPE  = 11'h002;
  localparam logic [10:0] CLS_LOAD   = 11'h004;
  localparam logic [10:0] CLS_STORE  = 11'h008;
  localparam logic [10:0] CLS_BRANCH = 11'h010;
  localparam logic [10:0] CLS_JAL    = 11'h020;
  localparam logic [10:0] CLS_JALR   = 11'h040;
  localparam logic [10:0] CLS_LUI    = 11'h080;
  localparam logic [10:0] CLS_AUIPC  = 11'h100;
  localparam logic [10:0] CLS_SYSTEM = 11'h200;
  localparam logic [10:0] CLS_FENCE  = 11'h400;

  localparam logic [13:0] ALU_ADD  = 14'h0001;
  localparam logic [13:0] ALU_SUB  = 14'h0002;
  localparam logic [13:0] ALU_SLT  = 14'h0004;
  localparam logic [13:0] ALU_SLTU = 14'h0008;
  localparam logic [13:0] ALU_XOR  = 14'h0010;
  localparam logic [13:0] ALU_OR   = 14'h0020;
  localparam logic [13:0] ALU_AND  = 14'h0040;
  localparam logic [13:0] ALU_SLL  = 14'h0080;
  localparam logic [13:0] ALU_SRL  = 14'h0100;
  localparam logic [13:0] ALU_SRA  = 14'h0200;
  localparam logic [13:0] ALU_EQ   = 14'h0400;
  localparam logic [13:0] ALU_NEQ  = 14'h0800;
  localparam logic [13:0] ALU_GE   = 14'h1000;
  localparam logic [13:0] ALU_GEU  = 14'h2000;

  localparam logic [3:0] EXC_NONE    = 4'h0;
  localparam logic [3:0] EXC_ILLEGAL = 4'h1;
  localparam logic [3:0] EXC_ECALL   = 4'h2;
  localparam logic [3:0] EXC_EBREAK  = 4'h4;
  localparam logic [3:0] EXC_MRET    = 4'h8;

  function automatic logic [31:0] imm_i(input logic [31:0] ins);
    imm_i = {{20{ins[31]}}, ins[31:20]};
  endfunction

  function automatic logic [31:0] imm_s(input logic [31:0] ins);
    imm_s = {{20{ins[31]}}, ins[31:25], ins[11:7]};
  endfunction

  function automatic logic [31:0] imm_b(input logic [31:0] ins);
    imm_b = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
  endfunction

  function automatic logic [31:0] imm_j(input logic [31:0] ins);
    imm_j = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
  endfunction

  function automatic logic [31:0] imm_u(input logic [31:0] ins);
    imm_u = {ins[31:12], 12'd0};
  endfunction

  // SUB only exists in register form; SRA is selected by bit 30 in both forms.
  function automatic logic [13:0] arith_alu(input logic [2:0] f3, input logic b30,
                                            input logic is_reg);
    case (f3)
      3'b000:  arith_alu = (is_reg && b30) ? ALU_SUB : ALU_ADD;
      3'b001:  arith_alu = ALU_SLL;
      3'b010:  arith_alu = ALU_SLT;
      3'b011:  arith_alu = ALU_SLTU;
      3'b100:  arith_alu = ALU_XOR;
      3'b101:  arith_alu = b30 ? ALU_SRA : ALU_SRL;
      3'b110:  arith_alu = ALU_OR;
      3'b111:  arith_alu = ALU_AND;
      default: arith_alu = 14'd0;
    endcase
  endfunction

  logic        stall_bit;
  logic        capture;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [10:0] dec_cls;
  logic [13:0] dec_alu;
  logic [31:0] dec_imm;
  logic [3:0]  dec_exc;

  logic [31:0] pc_d, pc_q;
  logic [4:0]  rs1_d, rs1_q, rs2_d, rs2_q, rd_d, rd_q;
  logic [31:0] imm_d, imm_q;
  logic [2:0]  funct3_d, funct3_q;
  logic [13:0] alu_d, alu_q;
  logic [10:0] cls_d, cls_q;
  logic [3:0]  exc_d, exc_q;
  logic        funct7_bit6_d, funct7_bit6_q;
  logic        next_clk_en_d, next_clk_en_q;

  assign stall_bit  = stall;
  assign capture    = clk_en & ~stall_bit & ~rst;
  assign opcode     = fetch_instr[6:0];
  assign funct3     = fetch_instr[14:12];
  assign next_stall = stall & ~flush;
  assign next_flush = flush;
  assign decode_rs1 = fetch_instr[19:15];
  assign decode_rs2 = fetch_instr[24:20];

  // Instruction field decode
  always_comb begin
    dec_cls = 11'd0;
    dec_alu = 14'd0;
    dec_imm = 32'd0;
    dec_exc = EXC_NONE;
    case (opcode)
      OPC_RTYPE: begin
        dec_cls = CLS_RTYPE;
        dec_alu = arith_alu(funct3, fetch_instr[30], 1'b1);
      end
      OPC_ITYPE: begin
        dec_cls = CLS_ITYPE;
        dec_alu = arith_alu(funct3, fetch_instr[30], 1'b0);
        dec_imm = imm_i(fetch_instr);
      end
      OPC_LOAD: begin
        dec_cls = CLS_LOAD;
        dec_alu = ALU_ADD;
        dec_imm = imm_i(fetch_instr);
        case (funct3)
          3'b000, 3'b001, 3'b010, 3'b100, 3'b101: dec_exc = EXC_NONE;
          default:                                dec_exc = EXC_ILLEGAL;
        endcase
      end
      OPC_STORE: begin
        dec_cls = CLS_STORE;
        dec_alu = ALU_ADD;
        dec_imm = imm_s(fetch_instr);
        case (funct3)
          3'b000, 3'b001, 3'b010: dec_exc = EXC_NONE;
          default:                dec_exc = EXC_ILLEGAL;
        endcase
      end
      OPC_BRANCH: begin
        dec_cls = CLS_BRANCH;
        dec_imm = imm_b(fetch_instr);
        case (funct3)
          3'b000:  dec_alu = ALU_EQ;
          3'b001:  dec_alu = ALU_NEQ;
          3'b100:  dec_alu = ALU_SLT;
          3'b101:  dec_alu = ALU_GE;
          3'b110:  dec_alu = ALU_SLTU;
          3'b111:  dec_alu = ALU_GEU;
          default: dec_exc = EXC_ILLEGAL;
        endcase
      end
      OPC_JAL: begin
        dec_cls = CLS_JAL;
        dec_alu = ALU_ADD;
        dec_imm = imm_j(fetch_instr);
      end
      OPC_JALR: begin
        dec_cls = CLS_JALR;
        dec_alu = ALU_ADD;
        dec_imm = imm_i(fetch_instr);
      end
      OPC_LUI: begin
        dec_cls = CLS_LUI;
        dec_alu = ALU_ADD;
        dec_imm = imm_u(fetch_instr);
      end
      OPC_AUIPC: begin
        dec_cls = CLS_AUIPC;
        dec_alu = ALU_ADD;
        dec_imm = imm_u(fetch_instr);
      end
      OPC_SYSTEM: begin
        dec_cls = CLS_SYSTEM;
        dec_imm = imm_i(fetch_instr);
        // CSR accesses are legal SYSTEM encodings that raise nothing here
        case (fetch_instr)
          32'h0000_0073: dec_exc = EXC_ECALL;
          32'h0010_0073: dec_exc = EXC_EBREAK;
          32'h3020_0073: dec_exc = EXC_MRET;
          default:       dec_exc = EXC_NONE;
        endcase
      end
      OPC_FENCE: begin
        dec_cls = CLS_FENCE;
      end
      default: begin
        dec_exc = EXC_ILLEGAL;
      end
    endcase
  end

  // Capture or hold the decoded fields; flush beats stall for the valid bit
  always_comb begin
    if (capture) begin
      pc_d          = fetch_pc;
      rs1_d         = fetch_instr[19:15];
      rs2_d         = fetch_instr[24:20];
      rd_d          = fetch_instr[11:7];
      imm_d         = dec_imm;
      funct3_d      = funct3;
      alu_d         = dec_alu;
      cls_d         = dec_cls;
      exc_d         = dec_exc;
      funct7_bit6_d = fetch_instr[30];
    end else begin
      pc_d          = pc_q;
      rs1_d         = rs1_q;
      rs2_d         = rs2_q;
      rd_d          = rd_q;
      imm_d         = imm_q;
      funct3_d      = funct3_q;
      alu_d         = alu_q;
      cls_d         = cls_q;
      exc_d         = exc_q;
      funct7_bit6_d = funct7_bit6_q;
    end

    if (flush) begin
      next_clk_en_d = 1'b0;
    end else if (!stall_bit) begin
      next_clk_en_d = clk_en;
    end else begin
      next_clk_en_d = next_clk_en_q;
    end
  end

  // Pipeline registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q          <= 32'd0;
      rs1_q         <= 5'd0;
      rs2_q         <= 5'd0;
      rd_q          <= 5'd0;
      imm_q         <= 32'd0;
      funct3_q      <= 3'd0;
      alu_q         <= 14'd0;
      cls_q         <= 11'd0;
      exc_q         <= 4'd0;
      funct7_bit6_q <= 1'b0;
      next_clk_en_q <= 1'b0;
    end else begin
      pc_q          <= pc_d;
      rs1_q         <= rs1_d;
      rs2_q         <= rs2_d;
      rd_q          <= rd_d;
      imm_q         <= imm_d;
      funct3_q      <= funct3_d;
      alu_q         <= alu_d;
      cls_q         <= cls_d;
      exc_q         <= exc_d;
      funct7_bit6_q <= funct7_bit6_d;
      next_clk_en_q <= next_clk_en_d;
    end
  end

  assign decode_pc          = pc_q;
  assign decode_r_rs1       = rs1_q;
  assign decode_r_rs2       = rs2_q;
  assign decode_r_rd        = rd_q;
  assign decode_imm         = imm_q;
  assign decode_funct3      = funct3_q;
  assign decode_alu_type    = alu_q;
  assign decode_opcode_type = cls_q;
  assign decode_exception   = exc_q;
  assign next_clk_en        = next_clk_en_q;

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: an instruction table plus stall/flush/reset sequences.
module tb_decode_stage;

  logic               clk = 1'b0;
  logic               rst;
  logic [31:0]        fetch_instr;
  logic [31:0]        fetch_pc;
  logic [31:0]        decode_pc;
  logic [4:0]         decode_rs1, decode_r_rs1, decode_rs2, decode_r_rs2, decode_r_rd;
  logic signed [31:0] decode_imm;
  logic [2:0]         decode_funct3;
  logic [13:0]        decode_alu_type;
  logic [10:0]        decode_opcode_type;
  logic [3:0]         decode_exception;
  logic               clk_en, next_clk_en, stall, next_stall, flush, next_flush;

  int n_cmp = 0;
  int n_bad = 0;

  decode_stage dut (
    .clk(clk), .rst(rst), .fetch_instr(fetch_instr), .fetch_pc(fetch_pc),
    .decode_pc(decode_pc), .decode_rs1(decode_rs1), .decode_r_rs1(decode_r_rs1),
    .decode_rs2(decode_rs2), .decode_r_rs2(decode_r_rs2), .decode_r_rd(decode_r_rd),
    .decode_imm(decode_imm), .decode_funct3(decode_funct3),
    .decode_alu_type(decode_alu_type), .decode_opcode_type(decode_opcode_type),
    .decode_exception(decode_exception), .clk_en(clk_en), .next_clk_en(next_clk_en),
    .stall(stall), .next_stall(next_stall), .flush(flush), .next_flush(next_flush)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    logic [10:0] cls;
    logic [13:0] alu;
    logic [3:0]  exc;
    logic [31:0] imm;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  f3;
  } vec_t;

  vec_t vecs [18];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " pc"},     decode_pc, 32'd0);
    chk({tag, " rs1"},    32'(decode_r_rs1), 32'd0);
    chk({tag, " rs2"},    32'(decode_r_rs2), 32'd0);
    chk({tag, " rd"},     32'(decode_r_rd), 32'd0);
    chk({tag, " imm"},    decode_imm, 32'd0);
    chk({tag, " funct3"}, 32'(decode_funct3), 32'd0);
    chk({tag, " alu"},    32'(decode_alu_type), 32'd0);
    chk({tag, " class"},  32'(decode_opcode_type), 32'd0);
    chk({tag, " exc"},    32'(decode_exception), 32'd0);
    chk({tag, " valid"},  32'(next_clk_en), 32'd0);
  endtask

  initial begin
    //               instr          cls      alu       exc   imm            rd     rs1    rs2    f3
    vecs[0]  = '{32'h402081b3, 11'h001, 14'h0002, 4'h0, 32'h00000000, 5'd3,  5'd1,  5'd2,  3'd0};
    vecs[1]  = '{32'hf6a04113, 11'h002, 14'h0010, 4'h0, 32'hffffff6a, 5'd2,  5'd0,  5'd10, 3'd4};
    vecs[2]  = '{32'h00008103, 11'h004, 14'h0001, 4'h0, 32'h00000000, 5'd2,  5'd1,  5'd0,  3'd0};
    vecs[3]  = '{32'hfe311e23, 11'h008, 14'h0001, 4'h0, 32'hfffffffc, 5'd28, 5'd2,  5'd3,  3'd1};
    vecs[4]  = '{32'hfe1158e3, 11'h010, 14'h1000, 4'h0, 32'hfffffff0, 5'd17, 5'd2,  5'd1,  3'd5};
    vecs[5]  = '{32'h010000ef, 11'h020, 14'h0001, 4'h0, 32'h00000010, 5'd1,  5'd0,  5'd16, 3'd0};
    vecs[6]  = '{32'h018081e7, 11'h040, 14'h0001, 4'h0, 32'h00000018, 5'd3,  5'd1,  5'd24, 3'd0};
    vecs[7]  = '{32'habcde097, 11'h100, 14'h0001, 4'h0, 32'habcde000, 5'd1,  5'd27, 5'd28, 3'd6};
    vecs[8]  = '{32'h30556473, 11'h200, 14'h0000, 4'h0, 32'h00000305, 5'd8,  5'd10, 5'd5,  3'd6};
    vecs[9]  = '{32'h0ff0000f, 11'h400, 14'h0000, 4'h0, 32'h00000000, 5'd0,  5'd0,  5'd31, 3'd0};
    vecs[10] = '{32'h00000000, 11'h000, 14'h0000, 4'h1, 32'h00000000, 5'd0,  5'd0,  5'd0,  3'd0};
    vecs[11] = '{32'h00000073, 11'h200, 14'h0000, 4'h2, 32'h00000000, 5'd0,  5'd0,  5'd0,  3'd0};
    vecs[12] = '{32'h00100073, 11'h200, 14'h0000, 4'h4, 32'h00000001, 5'd0,  5'd0,  5'd1,  3'd0};
    vecs[13] = '{32'h30200073, 11'h200, 14'h0000, 4'h8, 32'h00000302, 5'd0,  5'd0,  5'd2,  3'd0};
    vecs[14] = '{32'h00003003, 11'h004, 14'h0001, 4'h1, 32'h00000000, 5'd0,  5'd0,  5'd0,  3'd3};
    vecs[15] = '{32'h00002063, 11'h010, 14'h0000, 4'h1, 32'h00000000, 5'd0,  5'd0,  5'd0,  3'd2};
    vecs[16] = '{32'h4020d093, 11'h002, 14'h0200, 4'h0, 32'h00000402, 5'd1,  5'd1,  5'd2,  3'd5};
    vecs[17] = '{32'h800000b7, 11'h080, 14'h0001, 4'h0, 32'h80000000, 5'd1,  5'd0,  5'd0,  3'd0};

    rst = 1'b1; clk_en = 1'b0; stall = 1'b0; flush = 1'b0;
    fetch_instr = 32'h402081b3; fetch_pc = 32'h0000_1234;
    tick; tick;
    chk_all_zero("reset");

    rst = 1'b0;
    for (int i = 0; i < 18; i++) begin
      fetch_instr = vecs[i].instr;
      fetch_pc    = 32'(i * 4);
      clk_en      = 1'b1;
      #1;
      chk($sformatf("v%0d comb_rs1", i), 32'(decode_rs1), 32'(vecs[i].rs1));
      chk($sformatf("v%0d comb_rs2", i), 32'(decode_rs2), 32'(vecs[i].rs2));
      tick;
      chk($sformatf("v%0d pc", i),     decode_pc, 32'(i * 4));
      chk($sformatf("v%0d class", i),  32'(decode_opcode_type), 32'(vecs[i].cls));
      chk($sformatf("v%0d alu", i),    32'(decode_alu_type), 32'(vecs[i].alu));
      chk($sformatf("v%0d exc", i),    32'(decode_exception), 32'(vecs[i].exc));
      chk($sformatf("v%0d imm", i),    decode_imm, vecs[i].imm);
      chk($sformatf("v%0d rd", i),     32'(decode_r_rd), 32'(vecs[i].rd));
      chk($sformatf("v%0d rs1", i),    32'(decode_r_rs1), 32'(vecs[i].rs1));
      chk($sformatf("v%0d rs2", i),    32'(decode_r_rs2), 32'(vecs[i].rs2));
      chk($sformatf("v%0d funct3", i), 32'(decode_funct3), 32'(vecs[i].f3));
      chk($sformatf("v%0d valid", i),  32'(next_clk_en), 32'd1);
    end

    // Stall: fields and valid bit frozen even though clk_en drops
    fetch_instr = 32'h402081b3; fetch_pc = 32'h100; clk_en = 1'b1;
    tick;
    chk("pre_stall pc", decode_pc, 32'h100);
    stall = 1'b1; clk_en = 1'b0;
    fetch_instr = 32'hf6a04113; fetch_pc = 32'h200;
    #1;
    chk("stall next_stall", 32'(next_stall), 32'd1);
    chk("stall next_flush", 32'(next_flush), 32'd0);
    for (int c = 0; c < 2; c++) begin
      tick;
      chk($sformatf("stall%0d pc", c),    decode_pc, 32'h100);
      chk($sformatf("stall%0d class", c), 32'(decode_opcode_type), 32'h001);
      chk($sformatf("stall%0d alu", c),   32'(decode_alu_type), 32'h0002);
      chk($sformatf("stall%0d valid", c), 32'(next_clk_en), 32'd1);
    end
    stall = 1'b0; clk_en = 1'b1;
    tick;
    chk("release pc",    decode_pc, 32'h200);
    chk("release class", 32'(decode_opcode_type), 32'h002);
    chk("release imm",   decode_imm, 32'hffffff6a);
    chk("release valid", 32'(next_clk_en), 32'd1);

    // Flush together with stall
    stall = 1'b1; flush = 1'b1;
    fetch_instr = 32'habcde097; fetch_pc = 32'h300;
    #1;
    chk("flush next_flush", 32'(next_flush), 32'd1);
    chk("flush next_stall", 32'(next_stall), 32'd0);
    tick;
    chk("flush valid", 32'(next_clk_en), 32'd0);
    chk("flush pc",    decode_pc, 32'h200);

    // No valid fetch: valid drops, fields hold
    stall = 1'b0; flush = 1'b0; clk_en = 1'b0;
    tick;
    chk("idle valid", 32'(next_clk_en), 32'd0);
    chk("idle pc",    decode_pc, 32'h200);
    clk_en = 1'b1;
    tick;
    chk("resume pc",    decode_pc, 32'h300);
    chk("resume imm",   decode_imm, 32'habcde000);
    chk("resume valid", 32'(next_clk_en), 32'd1);

    // Reset mid-stream while a valid instruction is presented
    rst = 1'b1; fetch_instr = 32'hf6a04113; fetch_pc = 32'h400;
    tick;
    chk_all_zero("midrst");
    rst = 1'b0;
    tick;
    chk("post_rst pc",    decode_pc, 32'h400);
    chk("post_rst valid", 32'(next_clk_en), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
